// File: rtl/periph_hs_rx.sv
// periph_hs_rx: receive endpoint for a four-phase send/ack handshake.
// Each handshake captures exactly one DATA_W-bit word into a DEPTH-entry
// show-ahead FIFO. Ack is withheld while the FIFO is full (backpressure).
// A sticky error flag is raised when the sender keeps send asserted for
// TIMEOUT cycles of ack.
module periph_hs_rx #(
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       send,
  input  logic [DATA_W-1:0]          dado,
  output logic                       ack,
  input  logic                       rd_en,
  output logic [DATA_W-1:0]          rd_data,
  output logic                       rd_valid,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       err_timeout,
  input  logic                       err_clr
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int TO_W  = $clog2(TIMEOUT + 1);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);
  localparam logic [TO_W-1:0]  TO_ONE   = TO_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACK  = 2'd1,
    S_ERR  = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic              ack_q, ack_d;
  logic [TO_W-1:0]   tcnt_q, tcnt_d;
  logic              err_q, err_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic wr_en;
  logic pop;
  logic set_err;
  logic full_now;

  // Fullness is judged only from the registered count, so a pop in the
  // same cycle as a blocked send frees the slot one cycle later.
  assign full_now = (count_q == CNT_FULL);
  assign pop      = rd_en && (count_q != '0);

  // Handshake FSM: next state, timeout counter and FIFO write strobe.
  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    wr_en   = 1'b0;
    set_err = 1'b0;
    case (state_q)
      S_IDLE: begin
        tcnt_d = '0;
        if (send && !full_now) begin
          wr_en   = 1'b1;
          state_d = S_ACK;
        end
      end
      S_ACK: begin
        if (!send) begin
          state_d = S_IDLE;
          tcnt_d  = '0;
        end else if (tcnt_q == TO_LAST) begin
          state_d = S_ERR;
          set_err = 1'b1;
          tcnt_d  = '0;
        end else begin
          tcnt_d = tcnt_q + TO_ONE;
        end
      end
      S_ERR: begin
        // Stay here (no capture) until the sender finally releases send.
        tcnt_d = '0;
        if (!send) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        tcnt_d  = '0;
      end
    endcase
  end

  // Ack is a registered copy of "next state is ACK", so it is a clean
  // Moore output that rises and falls one cycle after send is sampled.
  always_comb begin
    ack_d = (state_d == S_ACK);
  end

  // Sticky timeout flag; a new timeout beats a simultaneous clear.
  always_comb begin
    err_d = err_q;
    if (set_err) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end
  end

  // FIFO pointer and occupancy bookkeeping; pointers wrap modulo DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    case ({wr_en, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      ack_q    <= 1'b0;
      tcnt_q   <= '0;
      err_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      ack_q    <= ack_d;
      tcnt_q   <= tcnt_d;
      err_q    <= err_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // FIFO storage; contents need no reset because occupancy gates them.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) begin
      mem_q[wr_ptr_q] <= dado;
    end
  end

  assign ack         = ack_q;
  assign rd_data     = mem_q[rd_ptr_q];
  assign rd_valid    = (count_q != '0);
  assign full        = full_now;
  assign count       = count_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_periph_hs_rx.sv
// Bench for periph_hs_rx: two instances (long and short timeout) share
// one stimulus stream; a queue-style model per instance is compared on
// every falling edge, and directed steps pin literal expectations.
module tb_periph_hs_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       send = 1'b0;
  logic [7:0] dado = 8'h00;
  logic       rd_en = 1'b0;
  logic       err_clr = 1'b0;

  logic       ack0, ack1;
  logic [7:0] rd_data0, rd_data1;
  logic       rd_valid0, rd_valid1;
  logic       full0, full1;
  logic [2:0] count0, count1;
  logic       err0, err1;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  periph_hs_rx #(.DATA_W(8), .DEPTH(4), .TIMEOUT(255)) u0 (
    .clk(clk), .rst(rst), .send(send), .dado(dado), .ack(ack0),
    .rd_en(rd_en), .rd_data(rd_data0), .rd_valid(rd_valid0),
    .full(full0), .count(count0), .err_timeout(err0), .err_clr(err_clr)
  );

  periph_hs_rx #(.DATA_W(8), .DEPTH(4), .TIMEOUT(4)) u1 (
    .clk(clk), .rst(rst), .send(send), .dado(dado), .ack(ack1),
    .rd_en(rd_en), .rd_data(rd_data1), .rd_valid(rd_valid1),
    .full(full1), .count(count1), .err_timeout(err1), .err_clr(err_clr)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (one per instance) ----------------
  int         m_to [2] = '{255, 4};
  bit         m_ack [2];
  bit         m_busy [2];   // current send-high episode already served
  int         m_held [2];   // ack cycles already spent with send high
  bit         m_err [2];
  logic [7:0] m_buf [2][4];
  int         m_head [2];
  int         m_size [2];

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_ack[i] = 0; m_busy[i] = 0; m_held[i] = 0; m_err[i] = 0;
        m_head[i] = 0; m_size[i] = 0;
      end else begin
        bit was_full, do_pop, do_wr, do_set;
        was_full = (m_size[i] == 4);
        do_pop = rd_en && (m_size[i] > 0);
        do_wr = 0;
        do_set = 0;
        if (!send) begin
          m_ack[i] = 0; m_busy[i] = 0; m_held[i] = 0;
        end else if (!m_busy[i]) begin
          if (!was_full) begin
            do_wr = 1; m_ack[i] = 1; m_busy[i] = 1; m_held[i] = 0;
          end
        end else if (m_ack[i]) begin
          if (m_held[i] + 1 == m_to[i]) begin
            m_ack[i] = 0; do_set = 1;
          end else begin
            m_held[i]++;
          end
        end
        if (do_set) m_err[i] = 1;
        else if (err_clr) m_err[i] = 0;
        if (do_pop) begin
          m_head[i] = (m_head[i] + 1) % 4;
          m_size[i]--;
        end
        if (do_wr) begin
          m_buf[i][(m_head[i] + m_size[i]) % 4] = dado;
          m_size[i]++;
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Compare both instances against the model on every falling edge.
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("u0.ack", ack0, m_ack[0]);
      chk("u0.count", count0, m_size[0]);
      chk("u0.full", full0, m_size[0] == 4);
      chk("u0.rd_valid", rd_valid0, m_size[0] > 0);
      chk("u0.err", err0, m_err[0]);
      if (m_size[0] > 0) chk("u0.rd_data", rd_data0, m_buf[0][m_head[0]]);
      chk("u1.ack", ack1, m_ack[1]);
      chk("u1.count", count1, m_size[1]);
      chk("u1.full", full1, m_size[1] == 4);
      chk("u1.rd_valid", rd_valid1, m_size[1] > 0);
      chk("u1.err", err1, m_err[1]);
      if (m_size[1] > 0) chk("u1.rd_data", rd_data1, m_buf[1][m_head[1]]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    tick(); tick();
    chk_en = 1'b1;
    rst = 1'b0;
    tick();
    $display("reset: ack=%0d count=%0d", ack0, count0);
    chk("reset.ack", ack0, 0);
    chk("reset.count", count0, 0);
    chk("reset.err", err0, 0);

    // Single handshake with 0xA5.
    send = 1; dado = 8'hA5; tick();
    $display("hs A5: ack=%0d rd_data=%0h", ack0, rd_data0);
    chk("hs1.ack_rise", ack0, 1);
    chk("hs1.rd_data", rd_data0, 8'hA5);
    send = 0; tick();
    $display("hs A5 release: ack=%0d count=%0d", ack0, count0);
    chk("hs1.ack_fall", ack0, 0);
    chk("hs1.count", count0, 1);
    rd_en = 1; tick(); rd_en = 0;

    // Send held for 10 cycles: one word on u0, timeout on u1.
    send = 1; dado = 8'h3C;
    for (int i = 1; i <= 10; i++) begin
      tick();
      $display("hold %0d: ack0=%0d ack1=%0d err1=%0d", i, ack0, ack1, err1);
      chk("hold.ack0", ack0, 1);
      chk("hold.ack1", ack1, (i <= 4) ? 1 : 0);
      chk("hold.err1", err1, (i >= 5) ? 1 : 0);
    end
    chk("hold.count0", count0, 1);
    chk("hold.err0", err0, 0);
    send = 0; tick();
    chk("hold.release_ack0", ack0, 0);
    chk("hold.err1_sticky", err1, 1);
    err_clr = 1; tick(); err_clr = 0;
    $display("err_clr: err1=%0d", err1);
    chk("errclr.err1", err1, 0);
    rd_en = 1; tick(); rd_en = 0;
    chk("drain.count0", count0, 0);

    // Fill the FIFO, then a fifth handshake is blocked until a pop.
    for (int k = 1; k <= 4; k++) begin
      send = 1; dado = 8'(k); tick();
      chk("fill.ack", ack0, 1);
      send = 0; tick();
    end
    chk("fill.full", full0, 1);
    send = 1; dado = 8'h05; tick();
    chk("blocked.ack", ack0, 0);
    tick();
    chk("blocked.ack2", ack0, 0);
    rd_en = 1; tick(); rd_en = 0;
    $display("pop while blocked: ack=%0d count=%0d", ack0, count0);
    chk("blocked.same_cycle", ack0, 0);
    chk("blocked.count", count0, 3);
    tick();
    chk("unblocked.ack", ack0, 1);
    chk("unblocked.count", count0, 4);
    send = 0; tick();
    rd_en = 1;
    for (int k = 2; k <= 5; k++) begin
      $display("drain: rd_data=%0h", rd_data0);
      chk("drain.order", rd_data0, k);
      tick();
    end
    chk("drain.empty", rd_valid0, 0);
    tick();
    chk("underflow.count", count0, 0);
    chk("underflow.valid", rd_valid0, 0);
    rd_en = 0;

    // Simultaneous write and pop at count=2.
    send = 1; dado = 8'h11; tick(); send = 0; tick();
    send = 1; dado = 8'h22; tick(); send = 0; tick();
    send = 1; dado = 8'h33; rd_en = 1; tick(); rd_en = 0;
    $display("wr+pop: count=%0d rd_data=%0h", count0, rd_data0);
    chk("wrpop.count", count0, 2);
    chk("wrpop.head", rd_data0, 8'h22);
    send = 0; tick();

    // Reset during ack with count=3, send still high afterwards.
    send = 1; dado = 8'h44; tick();
    chk("rstmid.pre_count", count0, 3);
    rst = 1; tick();
    $display("rst mid: ack=%0d count=%0d", ack0, count0);
    chk("rstmid.ack", ack0, 0);
    chk("rstmid.count", count0, 0);
    chk("rstmid.valid", rd_valid0, 0);
    rst = 0; dado = 8'h55; tick();
    chk("rstmid.recapture_ack", ack0, 1);
    chk("rstmid.recapture_data", rd_data0, 8'h55);
    send = 0; tick();

    // Randomized traffic checked cycle by cycle against the model.
    for (int c = 0; c < 4000; c++) begin
      rst = ($urandom_range(0, 399) == 0);
      if (!send) begin
        if ($urandom_range(0, 2) == 0) begin
          send = 1; dado = 8'($urandom);
        end
      end else if ($urandom_range(0, 3) == 0) begin
        send = 0;
      end
      rd_en = (c < 2000) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      err_clr = ($urandom_range(0, 15) == 0);
      tick();
    end
    rst = 0; send = 0; rd_en = 0; err_clr = 0;
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
